// File: rtl/uart_audio_pkg.sv
// ---------------------------------------------------------------------------
// uart_audio_pkg
// Shared definitions for the UART audio sample path: the byte-packer state
// encoding, default FIFO depth and the default inter-byte timeout.
// ---------------------------------------------------------------------------
package uart_audio_pkg;

    // Packer FSM: waiting for the low byte, or holding it and waiting for
    // the high byte.
    typedef enum logic {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } packer_state_t;

    localparam int DEPTH_DEFAULT          = 16;
    // 5 ms at 50 MHz between the low and the high byte.
    localparam int TIMEOUT_CYCLES_DEFAULT = 250000;
    localparam int TIMEOUT_CNT_W          = 18;
    localparam int SAMPLE_W               = 16;

endpackage : uart_audio_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The oldest entry is presented
// on pop_data_o whenever empty_o is low.
//
// Ports
//   CLK50MHz     system clock, rising edge
//   RESET        asynchronous active-low reset (pointers and count only)
//   push_i       write request; taken when not full, or when full and a pop
//                happens in the same cycle
//   push_data_i  write data
//   pop_i        read request; ignored while empty
//   pop_data_o   head entry (valid while empty_o = 0)
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   count_o      number of stored entries, 0..DEPTH
// DEPTH must be a power of two (2..256) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       CLK50MHz,
    input  logic                       RESET,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is deliberately not reset; only the bookkeeping is.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic wr_en;
    logic rd_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign rd_en = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Asynchronous read of the head entry gives fall-through behaviour:
    // a word written while empty is visible the cycle after the write.
    assign pop_data_o = mem_q[rd_ptr_q];

endmodule : sync_fifo

// File: rtl/uart_sample_packer.sv
// ---------------------------------------------------------------------------
// uart_sample_packer
// Pairs consecutive UART bytes (low byte first) into 16-bit audio samples
// and queues them in a FWFT FIFO for the audio block. A low byte that is not
// followed by its high byte within TIMEOUT_CYCLES is discarded so the byte
// stream resynchronises.
//
// Ports
//   CLK50MHz       system clock, rising edge
//   RESET          asynchronous active-low reset
//   rx_data        received byte
//   rx_valid       one-cycle strobe qualifying rx_data
//   sample_data    FIFO head {high, low}; valid while sample_valid = 1
//   sample_valid   FIFO non-empty
//   sample_ready   consumer accepts sample_data
//   fill_level     samples currently stored
//   overflow_flag  sticky: completed sample dropped on a full FIFO
//   timeout_flag   sticky: partial sample discarded on timeout
//   clr_flags      synchronous clear of both sticky flags (wins over set)
// ---------------------------------------------------------------------------
module uart_sample_packer
    import uart_audio_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     CLK50MHz,
    input  logic                     RESET,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [SAMPLE_W-1:0]      sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow_flag,
    output logic                     timeout_flag,
    input  logic                     clr_flags
);

    localparam logic [TIMEOUT_CNT_W-1:0] TMO_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

    packer_state_t             state_q, state_d;
    logic [7:0]                lo_byte_q, lo_byte_d;
    logic [TIMEOUT_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      tmo_flag_q, tmo_flag_d;

    logic                      push;
    logic                      tmo_event;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push_refused;

    always_comb begin
        state_d   = state_q;
        lo_byte_d = lo_byte_q;
        tmo_cnt_d = tmo_cnt_q;
        push      = 1'b0;
        tmo_event = 1'b0;
        case (state_q)
            WAIT_LO: begin
                tmo_cnt_d = '0;
                if (rx_valid) begin
                    lo_byte_d = rx_data;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A byte arriving in the timeout cycle still completes the
                // sample, so rx_valid is tested before the counter.
                if (rx_valid) begin
                    push      = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_LO;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_event = 1'b1;
                    lo_byte_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_LO;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = WAIT_LO;
                tmo_cnt_d = '0;
            end
        endcase
    end

    assign sample_valid = !fifo_empty;
    assign pop          = sample_valid && sample_ready;
    // Same acceptance rule the FIFO applies internally; mirrored here only to
    // raise the overflow flag.
    assign push_refused = push && fifo_full && !pop;

    always_comb begin
        ovf_d      = ovf_q;
        tmo_flag_d = tmo_flag_q;
        if (clr_flags) begin
            ovf_d      = 1'b0;
            tmo_flag_d = 1'b0;
        end else begin
            if (push_refused) begin
                ovf_d = 1'b1;
            end
            if (tmo_event) begin
                tmo_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK50MHz or negedge RESET) begin
        if (!RESET) begin
            state_q    <= WAIT_LO;
            lo_byte_q  <= '0;
            tmo_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_byte_q  <= lo_byte_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ovf_q      <= ovf_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign overflow_flag = ovf_q;
    assign timeout_flag  = tmo_flag_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .CLK50MHz    (CLK50MHz),
        .RESET       (RESET),
        .push_i      (push),
        .push_data_i ({rx_data, lo_byte_q}),
        .pop_i       (pop),
        .pop_data_o  (sample_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fill_level)
    );

endmodule : uart_sample_packer

// File: tb/tb_uart_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_uart_sample_packer
// Directed stimulus against a queue-based model of the sample packer, plus
// literal expectations at key points of each scenario. The timeout is
// shortened so the timeout scenarios finish quickly.
// ---------------------------------------------------------------------------
module tb_uart_sample_packer;

    localparam int DEPTH = 16;
    localparam int T     = 100;

    logic        CLK50MHz = 1'b0;
    logic        RESET;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [4:0]  fill_level;
    logic        overflow_flag;
    logic        timeout_flag;
    logic        clr_flags;

    int tests = 0;
    int fails = 0;

    uart_sample_packer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK50MHz      (CLK50MHz),
        .RESET         (RESET),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .fill_level    (fill_level),
        .overflow_flag (overflow_flag),
        .timeout_flag  (timeout_flag),
        .clr_flags     (clr_flags)
    );

    always #5 CLK50MHz = ~CLK50MHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mq[$];
    bit          m_pending = 1'b0;
    logic [7:0]  m_lo      = '0;
    int          m_age     = 0;
    bit          m_ovf     = 1'b0;
    bit          m_tmo     = 1'b0;

    always @(posedge CLK50MHz or negedge RESET) begin
        bit          pop_now;
        bit          have_s;
        bit          ovf_set;
        bit          tmo_set;
        logic [15:0] s;
        if (!RESET) begin
            mq.delete();
            m_pending = 1'b0;
            m_lo      = '0;
            m_age     = 0;
            m_ovf     = 1'b0;
            m_tmo     = 1'b0;
        end else begin
            pop_now = (mq.size() != 0) && sample_ready;
            have_s  = 1'b0;
            ovf_set = 1'b0;
            tmo_set = 1'b0;
            s       = '0;
            if (m_pending) begin
                m_age++;
                if (rx_valid) begin
                    s         = {rx_data, m_lo};
                    have_s    = 1'b1;
                    m_pending = 1'b0;
                end else if (m_age == T) begin
                    m_pending = 1'b0;
                    tmo_set   = 1'b1;
                end
            end else if (rx_valid) begin
                m_pending = 1'b1;
                m_lo      = rx_data;
                m_age     = 0;
            end
            if (pop_now) void'(mq.pop_front());
            if (have_s) begin
                if (mq.size() < DEPTH) mq.push_back(s);
                else ovf_set = 1'b1;
            end
            if (clr_flags) begin
                m_ovf = 1'b0;
                m_tmo = 1'b0;
            end else begin
                if (ovf_set) m_ovf = 1'b1;
                if (tmo_set) m_tmo = 1'b1;
            end
        end
    end

    // Per-cycle comparison, sampled between clock edges.
    always @(negedge CLK50MHz) begin
        #1;
        chk("cyc_valid", {31'd0, sample_valid}, {31'd0, mq.size() != 0});
        chk("cyc_fill", {27'd0, fill_level}, mq.size());
        if (mq.size() != 0) chk("cyc_data", {16'd0, sample_data}, {16'd0, mq[0]});
        chk("cyc_ovf", {31'd0, overflow_flag}, {31'd0, m_ovf});
        chk("cyc_tmo", {31'd0, timeout_flag}, {31'd0, m_tmo});
    end

    // Drives one byte for exactly one clock edge; call at a negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK50MHz);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge CLK50MHz);
        clr_flags = 1'b0;
    endtask

    initial begin
        RESET        = 1'b0;
        rx_data      = '0;
        rx_valid     = 1'b0;
        sample_ready = 1'b0;
        clr_flags    = 1'b0;
        repeat (3) @(negedge CLK50MHz);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_fill", {27'd0, fill_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_flag}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_flag}, 32'd0);
        RESET = 1'b1;
        @(negedge CLK50MHz);

        // Basic pair with consumer ready.
        sample_ready = 1'b1;
        send_byte(8'h34);
        send_byte(8'h12);
        chk("basic_valid", {31'd0, sample_valid}, 32'd1);
        chk("basic_data", {16'd0, sample_data}, 32'h1234);
        @(negedge CLK50MHz);
        chk("basic_fill0", {27'd0, fill_level}, 32'd0);

        // Overflow: 34 samples into a stalled 16-deep FIFO.
        sample_ready = 1'b0;
        for (int i = 0; i < 34; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
        end
        chk("ovf_fill", {27'd0, fill_level}, 32'd16);
        chk("ovf_flag", {31'd0, overflow_flag}, 32'd1);
        // Dropped push with clr_flags in the same cycle: clear wins.
        send_byte(8'h77);
        rx_data   = 8'h00;
        rx_valid  = 1'b1;
        clr_flags = 1'b1;
        @(negedge CLK50MHz);
        rx_valid  = 1'b0;
        clr_flags = 1'b0;
        chk("clr_wins", {31'd0, overflow_flag}, 32'd0);
        chk("clr_fill", {27'd0, fill_level}, 32'd16);
        sample_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", {16'd0, sample_data}, i);
            @(negedge CLK50MHz);
        end
        chk("drain_empty", {31'd0, sample_valid}, 32'd0);

        // Timeout discards a lone low byte.
        send_byte(8'hAA);
        repeat (T + 5) @(negedge CLK50MHz);
        chk("tmo_flag", {31'd0, timeout_flag}, 32'd1);
        chk("tmo_nodata", {31'd0, sample_valid}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("tmo_data", {16'd0, sample_data}, 32'h0201);
        @(negedge CLK50MHz);
        chk("tmo_fill0", {27'd0, fill_level}, 32'd0);
        pulse_clr();

        // High byte one edge before the timeout edge.
        send_byte(8'h11);
        repeat (T - 2) @(negedge CLK50MHz);
        send_byte(8'h22);
        chk("edge_m1_data", {16'd0, sample_data}, 32'h2211);
        chk("edge_m1_tmo", {31'd0, timeout_flag}, 32'd0);
        @(negedge CLK50MHz);
        // High byte exactly on the timeout edge: the byte wins.
        send_byte(8'h33);
        repeat (T - 1) @(negedge CLK50MHz);
        send_byte(8'h44);
        chk("edge_data", {16'd0, sample_data}, 32'h4433);
        chk("edge_tmo", {31'd0, timeout_flag}, 32'd0);
        @(negedge CLK50MHz);

        // Full FIFO, pop and completing push in the same cycle.
        sample_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            send_byte(8'h01);
        end
        send_byte(8'hEF);
        rx_data      = 8'hBE;
        rx_valid     = 1'b1;
        sample_ready = 1'b1;
        @(negedge CLK50MHz);
        rx_valid     = 1'b0;
        sample_ready = 1'b0;
        chk("simul_fill", {27'd0, fill_level}, 32'd16);
        chk("simul_ovf", {31'd0, overflow_flag}, 32'd0);
        sample_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("simul_drain", {16'd0, sample_data}, 32'h0100 + i);
            @(negedge CLK50MHz);
        end
        chk("simul_last", {16'd0, sample_data}, 32'hBEEF);
        @(negedge CLK50MHz);
        chk("simul_empty", {31'd0, sample_valid}, 32'd0);

        // Reset mid-sample, with a sticky flag set beforehand.
        send_byte(8'h99);
        repeat (T + 3) @(negedge CLK50MHz);
        chk("pre_rst_tmo", {31'd0, timeout_flag}, 32'd1);
        send_byte(8'h55);
        RESET = 1'b0;
        repeat (2) @(negedge CLK50MHz);
        RESET = 1'b1;
        @(negedge CLK50MHz);
        send_byte(8'h10);
        send_byte(8'h20);
        chk("rst_mid_data", {16'd0, sample_data}, 32'h2010);
        chk("rst_mid_ovf", {31'd0, overflow_flag}, 32'd0);
        chk("rst_mid_tmo", {31'd0, timeout_flag}, 32'd0);
        repeat (3) @(negedge CLK50MHz);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_sample_packer
